// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_pkg
//  Description : Shared funct codes, FSM/op-kind enums and decode helper for
//                the iterative HI/LO multiply/divide unit.
//  Revision    : 1.0
// ============================================================================
package muldiv_pkg;

  localparam logic [5:0] FUNC_MULT  = 6'b011000;
  localparam logic [5:0] FUNC_MULTU = 6'b011001;
  localparam logic [5:0] FUNC_DIV   = 6'b011010;
  localparam logic [5:0] FUNC_DIVU  = 6'b011011;
  localparam logic [5:0] FUNC_MFHI  = 6'b010000;
  localparam logic [5:0] FUNC_MTHI  = 6'b010001;
  localparam logic [5:0] FUNC_MFLO  = 6'b010010;
  localparam logic [5:0] FUNC_MTLO  = 6'b010011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  typedef enum logic [0:0] {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_kind_t;

  // True for every funct code this unit owns (arithmetic and HI/LO moves).
  function automatic logic is_muldiv_funct(input logic [5:0] f);
    case (f)
      FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU,
      FUNC_MFHI, FUNC_MTHI, FUNC_MFLO, FUNC_MTLO: is_muldiv_funct = 1'b1;
      default:                                    is_muldiv_funct = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_if
//  Description : EX-stage request/response bundle between the pipeline and
//                the multiply/divide unit.
//  Revision    : 1.0
// ============================================================================
interface muldiv_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [5:0]        function_field;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              stall;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] mf_data;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output start, function_field, op_a, op_b,
    input  stall, busy, done, mf_data, hi, lo
  );

  modport slave (
    input  start, function_field, op_a, op_b,
    output stall, busy, done, mf_data, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_step
//  Description : One radix-2 iteration. Multiply: LSB-first shift-add on
//                {carry, upper, multiplier}. Divide: MSB-first restoring
//                shift-subtract on {remainder(W+1), quotient/dividend(W)}.
//  Revision    : 1.0
// ============================================================================
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  op_kind_t          i_mode,
  input  logic [2*DATA_W:0] i_acc,
  input  logic [DATA_W-1:0] i_operand,
  output logic [2*DATA_W:0] o_acc
);

  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_shifted;
  logic [DATA_W+1:0] w_trial;

  // Single combinational step; the divide trial uses one extra bit as borrow.
  always_comb begin
    w_sum     = i_acc[2*DATA_W:DATA_W]
              + (i_acc[0] ? {1'b0, i_operand} : {(DATA_W+1){1'b0}});
    w_shifted = i_acc[2*DATA_W-1:DATA_W-1];
    w_trial   = {1'b0, w_shifted} - {2'b00, i_operand};
    o_acc     = '0;
    if (i_mode == OP_MUL) begin
      o_acc = {1'b0, w_sum, i_acc[DATA_W-1:1]};
    end else if (!w_trial[DATA_W+1]) begin
      o_acc = {w_trial[DATA_W:0], i_acc[DATA_W-2:0], 1'b1};
    end else begin
      o_acc = {w_shifted, i_acc[DATA_W-2:0], 1'b0};
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO
//                registers; also serves MFHI/MFLO/MTHI/MTLO and stalls EX
//                while an operation is in flight.
//  Revision    : 1.0
// ============================================================================
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input logic     clk,
  input logic     arst_n,
  muldiv_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam int ACC_W = 2 * DATA_W + 1;
  localparam logic [CNT_W-1:0] c_cnt_step = CNT_W'(BITS_PER_CYCLE);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DATA_W);

  state_t              r_state;
  state_t              w_state_nxt;
  op_kind_t            r_kind;
  logic                r_neg_a;
  logic                r_neg_b;
  logic                r_div0;
  logic [CNT_W-1:0]    r_cnt;
  logic [ACC_W-1:0]    r_acc;
  logic [DATA_W-1:0]   r_operand;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;
  logic                r_done;

  logic                w_idle;
  logic                w_start_arith;
  logic                w_signed;
  logic                w_a_neg;
  logic                w_b_neg;
  logic [DATA_W-1:0]   w_a_mag;
  logic [DATA_W-1:0]   w_b_mag;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W-1:0]   w_quot;
  logic [DATA_W-1:0]   w_rem;
  logic [DATA_W-1:0]   w_fix_hi;
  logic [DATA_W-1:0]   w_fix_lo;
  logic [DATA_W-1:0]   w_mf_data;

  logic [BITS_PER_CYCLE:0][ACC_W-1:0] w_chain;

  // Request decode and operand magnitudes (unsigned ops pass raw values).
  always_comb begin
    w_idle        = (r_state == IDLE);
    w_start_arith = bus.start &&
                    ((bus.function_field == FUNC_MULT) || (bus.function_field == FUNC_MULTU) ||
                     (bus.function_field == FUNC_DIV)  || (bus.function_field == FUNC_DIVU));
    w_signed      = ~bus.function_field[0];
    w_a_neg       = w_signed & bus.op_a[DATA_W-1];
    w_b_neg       = w_signed & bus.op_b[DATA_W-1];
    w_a_mag       = w_a_neg ? (~bus.op_a + 1'b1) : bus.op_a;
    w_b_mag       = w_b_neg ? (~bus.op_b + 1'b1) : bus.op_b;
    w_cnt_nxt     = r_cnt + c_cnt_step;
  end

  // Chain of BITS_PER_CYCLE radix-2 steps evaluated each RUN cycle.
  assign w_chain[0] = r_acc;
  generate
    for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
      muldiv_step #(.DATA_W(DATA_W)) u_step (
        .i_mode    (r_kind),
        .i_acc     (w_chain[gi]),
        .i_operand (r_operand),
        .o_acc     (w_chain[gi+1])
      );
    end
  endgenerate

  // Sign correction; a zero divisor keeps the all-ones quotient un-negated.
  always_comb begin
    w_prod = r_acc[2*DATA_W-1:0];
    if (r_neg_a ^ r_neg_b) w_prod = ~r_acc[2*DATA_W-1:0] + 1'b1;
    w_quot = r_acc[DATA_W-1:0];
    if ((r_neg_a ^ r_neg_b) && !r_div0) w_quot = ~r_acc[DATA_W-1:0] + 1'b1;
    w_rem = r_acc[2*DATA_W-1:DATA_W];
    if (r_neg_a) w_rem = ~r_acc[2*DATA_W-1:DATA_W] + 1'b1;
    if (r_kind == OP_MUL) begin
      w_fix_hi = w_prod[2*DATA_W-1:DATA_W];
      w_fix_lo = w_prod[DATA_W-1:0];
    end else begin
      w_fix_hi = w_rem;
      w_fix_lo = w_quot;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM next-state: arithmetic starts only from IDLE; RUN ends on the count.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start_arith) w_state_nxt = RUN;
      RUN:     if (w_cnt_nxt == c_cnt_last) w_state_nxt = FIX;
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: operand latch, iteration, HI/LO writes and the done pulse.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_kind    <= OP_MUL;
      r_neg_a   <= 1'b0;
      r_neg_b   <= 1'b0;
      r_div0    <= 1'b0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_operand <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start_arith) begin
            r_neg_a <= w_a_neg;
            r_neg_b <= w_b_neg;
            r_cnt   <= '0;
            if (bus.function_field[1]) begin
              r_kind    <= OP_DIV;
              r_div0    <= (bus.op_b == '0);
              r_acc     <= {{(DATA_W+1){1'b0}}, w_a_mag};
              r_operand <= w_b_mag;
            end else begin
              r_kind    <= OP_MUL;
              r_div0    <= 1'b0;
              r_acc     <= {{(DATA_W+1){1'b0}}, w_b_mag};
              r_operand <= w_a_mag;
            end
          end else if (bus.start && bus.function_field == FUNC_MTHI) begin
            r_hi <= bus.op_a;
          end else if (bus.start && bus.function_field == FUNC_MTLO) begin
            r_lo <= bus.op_a;
          end
        end
        RUN: begin
          r_acc <= w_chain[BITS_PER_CYCLE];
          r_cnt <= w_cnt_nxt;
        end
        FIX: begin
          r_hi   <= w_fix_hi;
          r_lo   <= w_fix_lo;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Same-cycle HI/LO read path for MFHI/MFLO.
  always_comb begin
    w_mf_data = '0;
    if (bus.start && bus.function_field == FUNC_MFHI) w_mf_data = r_hi;
    if (bus.start && bus.function_field == FUNC_MFLO) w_mf_data = r_lo;
  end

  assign bus.busy    = ~w_idle;
  assign bus.stall   = bus.start & ~w_idle & is_muldiv_funct(bus.function_field);
  assign bus.done    = r_done;
  assign bus.mf_data = w_mf_data;
  assign bus.hi      = r_hi;
  assign bus.lo      = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Directed self-checking bench for muldiv_unit (radix-2 x1
//                and x4 instances).
//  Revision    : 1.0
// ============================================================================
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic arst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  muldiv_if #(.DATA_W(W)) bus1 ();
  muldiv_if #(.DATA_W(W)) bus4 ();

  muldiv_unit #(.DATA_W(W), .BITS_PER_CYCLE(1)) dut1 (.clk(clk), .arst_n(arst_n), .bus(bus1));
  muldiv_unit #(.DATA_W(W), .BITS_PER_CYCLE(4)) dut4 (.clk(clk), .arst_n(arst_n), .bus(bus4));

  // Present one request to dut1 for exactly one rising edge.
  task automatic issue1(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus1.start = 1'b1; bus1.function_field = f; bus1.op_a = a; bus1.op_b = b;
    @(negedge clk);
    bus1.start = 1'b0; bus1.function_field = 6'b0;
  endtask

  // Count cycles until done; optionally probe stall with an MFLO on one cycle.
  task automatic wait_done1(input int probe, output int lat, output int busy_low, output logic stall_seen);
    lat = -1; busy_low = 0; stall_seen = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (bus1.done) begin lat = n; break; end
      if (!bus1.busy) busy_low++;
      if (n == probe) begin
        bus1.start = 1'b1; bus1.function_field = FUNC_MFLO;
        #1 stall_seen = bus1.stall;
        #1 bus1.start = 1'b0; bus1.function_field = 6'b0;
      end
    end
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    #12;
    checks++; if (bus1.hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected %h", bus1.hi, 32'h0); end
    checks++; if (bus1.lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected %h", bus1.lo, 32'h0); end
    checks++; if (bus1.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus1.busy); end
    checks++; if (bus1.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus1.done); end
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  task automatic test_mt_mf();
    @(negedge clk);
    bus1.start = 1'b1; bus1.function_field = FUNC_MTHI; bus1.op_a = 32'hA5A5A5A5;
    #1;
    checks++; if (bus1.stall !== 1'b0) begin errors++; $display("FAIL mthi_stall: got %b expected 0", bus1.stall); end
    @(negedge clk);
    bus1.function_field = FUNC_MFHI; bus1.op_a = 32'h0;
    #1;
    checks++; if (bus1.hi !== 32'hA5A5A5A5) begin errors++; $display("FAIL mthi_hi: got %h expected %h", bus1.hi, 32'hA5A5A5A5); end
    checks++; if (bus1.mf_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL mfhi_data: got %h expected %h", bus1.mf_data, 32'hA5A5A5A5); end
    checks++; if (bus1.stall !== 1'b0) begin errors++; $display("FAIL mfhi_stall: got %b expected 0", bus1.stall); end
    @(negedge clk);
    bus1.function_field = FUNC_MTLO; bus1.op_a = 32'h5A5A0001;
    @(negedge clk);
    bus1.function_field = FUNC_MFLO; bus1.op_a = 32'h0;
    #1;
    checks++; if (bus1.mf_data !== 32'h5A5A0001) begin errors++; $display("FAIL mflo_data: got %h expected %h", bus1.mf_data, 32'h5A5A0001); end
    checks++; if (bus1.hi !== 32'hA5A5A5A5) begin errors++; $display("FAIL mtlo_keeps_hi: got %h expected %h", bus1.hi, 32'hA5A5A5A5); end
    @(negedge clk);
    bus1.function_field = 6'b100000; bus1.op_a = 32'h1111; bus1.op_b = 32'h2222;
    #1;
    checks++; if (bus1.stall !== 1'b0) begin errors++; $display("FAIL other_stall: got %b expected 0", bus1.stall); end
    checks++; if (bus1.mf_data !== 32'h0) begin errors++; $display("FAIL other_mf_data: got %h expected 0", bus1.mf_data); end
    @(negedge clk);
    bus1.start = 1'b0; bus1.function_field = 6'b0;
    checks++; if (bus1.busy !== 1'b0) begin errors++; $display("FAIL other_busy: got %b expected 0", bus1.busy); end
  endtask

  task automatic test_reset_abort();
    int done_seen;
    done_seen = 0;
    issue1(FUNC_MULT, 32'd7, 32'd9);
    repeat (10) @(negedge clk);
    checks++; if (bus1.busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b expected 1", bus1.busy); end
    #2 arst_n = 1'b0;
    #1;
    checks++; if (bus1.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", bus1.busy); end
    checks++; if (bus1.hi !== 32'h0) begin errors++; $display("FAIL abort_hi: got %h expected 0", bus1.hi); end
    checks++; if (bus1.lo !== 32'h0) begin errors++; $display("FAIL abort_lo: got %h expected 0", bus1.lo); end
    @(negedge clk);
    arst_n = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus1.done) done_seen++;
    end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL abort_no_done: got %0d expected 0", done_seen); end
  endtask

  task automatic test_mult_signed();
    int lat, bl; logic st;
    issue1(FUNC_MULT, 32'hFFFFFFFD, 32'd5);
    wait_done1(5, lat, bl, st);
    checks++; if (lat !== 33) begin errors++; $display("FAIL mult_latency: got %0d expected 33", lat); end
    checks++; if (bl !== 0) begin errors++; $display("FAIL mult_busy_gap: got %0d expected 0", bl); end
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL mult_mflo_stall: got %b expected 1", st); end
    checks++; if (bus1.busy !== 1'b0) begin errors++; $display("FAIL mult_busy_done: got %b expected 0", bus1.busy); end
    checks++; if (bus1.hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi: got %h expected %h", bus1.hi, 32'hFFFFFFFF); end
    checks++; if (bus1.lo !== 32'hFFFFFFF1) begin errors++; $display("FAIL mult_lo: got %h expected %h", bus1.lo, 32'hFFFFFFF1); end
    @(negedge clk);
    checks++; if (bus1.done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse: got %b expected 0", bus1.done); end
  endtask

  task automatic test_multu_vs_mult();
    int lat, bl; logic st;
    issue1(FUNC_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done1(0, lat, bl, st);
    checks++; if (bus1.hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi: got %h expected %h", bus1.hi, 32'hFFFFFFFE); end
    checks++; if (bus1.lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo: got %h expected %h", bus1.lo, 32'h1); end
    issue1(FUNC_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done1(0, lat, bl, st);
    checks++; if (bus1.hi !== 32'h0) begin errors++; $display("FAIL mult_m1_hi: got %h expected 0", bus1.hi); end
    checks++; if (bus1.lo !== 32'h1) begin errors++; $display("FAIL mult_m1_lo: got %h expected 1", bus1.lo); end
  endtask

  task automatic test_div();
    int lat, bl; logic st;
    issue1(FUNC_DIV, 32'hFFFFFFF9, 32'd2);
    wait_done1(0, lat, bl, st);
    checks++; if (lat !== 33) begin errors++; $display("FAIL div_latency: got %0d expected 33", lat); end
    checks++; if (bus1.lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo: got %h expected %h", bus1.lo, 32'hFFFFFFFD); end
    checks++; if (bus1.hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi: got %h expected %h", bus1.hi, 32'hFFFFFFFF); end
    issue1(FUNC_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done1(0, lat, bl, st);
    checks++; if (bus1.lo !== 32'h80000000) begin errors++; $display("FAIL div_ovf_lo: got %h expected %h", bus1.lo, 32'h80000000); end
    checks++; if (bus1.hi !== 32'h0) begin errors++; $display("FAIL div_ovf_hi: got %h expected 0", bus1.hi); end
  endtask

  task automatic test_div_zero();
    int lat, bl; logic st;
    issue1(FUNC_DIVU, 32'h1234, 32'h0);
    wait_done1(0, lat, bl, st);
    checks++; if (lat !== 33) begin errors++; $display("FAIL divu0_latency: got %0d expected 33", lat); end
    checks++; if (bus1.lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL divu0_lo: got %h expected %h", bus1.lo, 32'hFFFFFFFF); end
    checks++; if (bus1.hi !== 32'h00001234) begin errors++; $display("FAIL divu0_hi: got %h expected %h", bus1.hi, 32'h1234); end
    issue1(FUNC_DIV, 32'hFFFFFFF8, 32'h0);
    wait_done1(0, lat, bl, st);
    checks++; if (bus1.lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL div0_lo: got %h expected %h", bus1.lo, 32'hFFFFFFFF); end
    checks++; if (bus1.hi !== 32'hFFFFFFF8) begin errors++; $display("FAIL div0_hi: got %h expected %h", bus1.hi, 32'hFFFFFFF8); end
  endtask

  task automatic test_back_to_back();
    int lat, bl; logic st;
    issue1(FUNC_DIVU, 32'd100, 32'd7);
    @(negedge clk);
    bus1.start = 1'b1; bus1.function_field = FUNC_MULTU; bus1.op_a = 32'd3; bus1.op_b = 32'd3;
    #1;
    checks++; if (bus1.stall !== 1'b1) begin errors++; $display("FAIL busy_op_stall: got %b expected 1", bus1.stall); end
    #1 bus1.start = 1'b0; bus1.function_field = 6'b0;
    wait_done1(0, lat, bl, st);
    checks++; if (lat !== 32) begin errors++; $display("FAIL divu_latency: got %0d expected 32", lat); end
    checks++; if (bus1.lo !== 32'd14) begin errors++; $display("FAIL divu_lo: got %h expected %h", bus1.lo, 32'd14); end
    checks++; if (bus1.hi !== 32'd2) begin errors++; $display("FAIL divu_hi: got %h expected %h", bus1.hi, 32'd2); end
    bus1.start = 1'b1; bus1.function_field = FUNC_MULTU; bus1.op_a = 32'd3; bus1.op_b = 32'd3;
    @(negedge clk);
    bus1.start = 1'b0; bus1.function_field = 6'b0;
    wait_done1(0, lat, bl, st);
    checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_latency: got %0d expected 33", lat); end
    checks++; if (bus1.lo !== 32'd9) begin errors++; $display("FAIL b2b_lo: got %h expected %h", bus1.lo, 32'd9); end
    checks++; if (bus1.hi !== 32'd0) begin errors++; $display("FAIL b2b_hi: got %h expected 0", bus1.hi); end
  endtask

  task automatic test_bpc4();
    int lat;
    lat = -1;
    @(negedge clk);
    bus4.start = 1'b1; bus4.function_field = FUNC_MULTU; bus4.op_a = 32'h12345678; bus4.op_b = 32'h9ABCDEF0;
    @(negedge clk);
    bus4.start = 1'b0; bus4.function_field = 6'b0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (bus4.done) begin lat = n; break; end
    end
    checks++; if (lat !== 9) begin errors++; $display("FAIL bpc4_latency: got %0d expected 9", lat); end
    checks++; if (bus4.hi !== 32'h0B00EA4E) begin errors++; $display("FAIL bpc4_hi: got %h expected %h", bus4.hi, 32'h0B00EA4E); end
    checks++; if (bus4.lo !== 32'h242D2080) begin errors++; $display("FAIL bpc4_lo: got %h expected %h", bus4.lo, 32'h242D2080); end
  endtask

  initial begin
    bus1.start = 1'b0; bus1.function_field = 6'b0; bus1.op_a = '0; bus1.op_b = '0;
    bus4.start = 1'b0; bus4.function_field = 6'b0; bus4.op_a = '0; bus4.op_b = '0;
    test_reset();
    test_mt_mf();
    test_reset_abort();
    test_mult_signed();
    test_multu_vs_mult();
    test_div();
    test_div_zero();
    test_back_to_back();
    test_bpc4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit holding architectural HI/LO registers for the MIPS datapath.
- Sits beside the ALU in EX. Takes the R-type function field directly for MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO and raises a stall to the hazard logic while busy.
- Parametrised in data width and bits retired per cycle. This trades latency for area.

Parameters:
- DATA_W, 32, operand/HI/LO width.
- BITS_PER_CYCLE, 1, radix-2 steps per clock. Must divide DATA_W; legal values 1, 2, 4, 8.

Ports:
- clk  input  1  system clock, rising edge
- arst_n  input  1  asynchronous active-low reset
- start  input  1  instruction in EX targets this unit
- function_field  input  6  instruction funct bits
- op_a  input  DATA_W  rs value (dividend/multiplicand; MTHI/MTLO source)
- op_b  input  DATA_W  rt value (divisor/multiplier)
- stall  output  1  start asserted while busy; pipeline must hold EX
- busy  output  1  iteration in progress
- done  output  1  one-cycle pulse when HI/LO updated by MULT*/DIV*
- mf_data  output  DATA_W  HI for MFHI, LO for MFLO, else 0 (combinational)
- hi  output  DATA_W  HI register
- lo  output  DATA_W  LO register

Behaviour:
- Reset (async, arst_n=0): state=IDLE, hi=0, lo=0, busy=0, done=0, iteration counter=0, internal accumulators=0.
- Funct codes: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011. Any other code with start=1 is ignored: no stall, no state change.
- FSM has three states: IDLE, RUN, FIX.
- IDLE, start, MULT*/DIV*:
  - Latch |op_a|, |op_b| for the signed ops, raw values for the unsigned ops.
  - Latch the signs and the op kind; clear the counter; go to RUN. busy=1 from the next cycle.
- IDLE, start, MTHI/MTLO: write op_a to hi/lo at that edge; remain IDLE.
- IDLE, start, MFHI/MFLO: mf_data is valid the same cycle, no stall.
- RUN:
  - Each edge performs BITS_PER_CYCLE shift-add (multiply) or restoring shift-subtract (divide) steps and advances the counter by BITS_PER_CYCLE.
  - When the counter reaches DATA_W, go to FIX.
- FIX:
  - Apply sign correction. Product is negated if the signs differ. Quotient is negated if the signs differ. Remainder takes the sign of the dividend.
  - Write hi/lo: multiply gives {hi,lo}=2*DATA_W product; divide gives lo=quotient, hi=remainder.
  - Assert done for exactly one cycle; go to IDLE. busy=0 in the done cycle.
- Latency: start sampled at edge k gives hi/lo valid and done=1 after edge k+DATA_W/BITS_PER_CYCLE+1. With the defaults this is 33 cycles.
- stall = start & busy & (funct is any of the 8 codes above), with busy taken from state≠IDLE. This covers MFHI/MFLO/MTHI/MTLO issued during RUN/FIX: they stall and are not executed. A new MULT/DIV issued while busy also stalls and is ignored; it is accepted once the pipeline re-presents it in IDLE.
- Divide by zero (op_b=0), both signed and unsigned: lo={DATA_W{1}}, hi=op_a (original, not abs). Same latency, no exception.
- Signed overflow: INT_MIN/-1 gives lo=INT_MIN, hi=0. This follows naturally from unsigned magnitude division plus wrap-around negation.
- Width rules:
  - Magnitudes are DATA_W bits unsigned, so |INT_MIN| is representable.
  - Multiply accumulator is 2*DATA_W+1 bits internally (carry).
  - Remainder register is DATA_W+1 bits for the trial subtract.
- Async reset mid-RUN aborts the operation, clears hi/lo, drops busy immediately, and produces no done.
- done and MTHI/MTLO can never coincide, because MT* in FIX stalls.

Decomposition:
- Package muldiv_pkg holds:
  - the funct localparams (FUNC_MULT … FUNC_MTLO);
  - the state enum (IDLE, RUN, FIX);
  - the op-kind enum (OP_MUL, OP_DIV);
  - the function is_muldiv_funct().
- Sub-module muldiv_step: one combinational radix-2 step (mode, acc, operand in; acc out). It is instantiated BITS_PER_CYCLE times in a generate chain inside muldiv_unit.

Test Plan (DATA_W=32, BITS_PER_CYCLE=1 unless stated):
- MULT a=0xFFFFFFFD (-3), b=5 -> after 33 cycles done=1, hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high for cycles 1..32, stall=1 for any MFLO presented then.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; MULT with the same operands -> hi=0, lo=1.
- DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x00001234, done after 33 cycles.
- MTHI 0xA5A5A5A5 then MFHI in IDLE -> hi updated at the next edge, mf_data=0xA5A5A5A5, stall=0. Then start MULT, pull arst_n low at cycle 10 -> hi=lo=0, busy=0, no done.
- BITS_PER_CYCLE=4: MULTU 0x12345678 × 0x9ABCDEF0 -> done after 9 cycles, {hi,lo}=0x0B00EA4E_242D2080.
